// File: rtl/d_ff.sv
// D flip-flop with async active-low clear (res) and preset (pre); clear dominates preset.
// Latency: d reaches q on the first rising clk edge; res/pre act immediately.
// Backpressure: none, and there is no enable, so every edge captures while res=1 and pre=1.
module d_ff #(
    parameter int unsigned           WIDTH          = 1,
    parameter logic [WIDTH-1:0]      INIT_ON_PRESET = {WIDTH{1'b1}}
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             res,
    input  logic             pre
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             set_n;

    // Preset is gated by clear, so releasing res while pre is still low
    // produces a falling edge here and loads the preset value at once.
    assign set_n = pre | ~res;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or negedge res or negedge set_n) begin
        if (!res) begin
            q_q <= '0;
        end else if (!set_n) begin
            q_q <= INIT_ON_PRESET;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: table of async/edge vectors, hand sequences, and an 8-bit rotate built from instances.
module tb_d_ff;

    logic       clk = 1'b0;
    logic       res;
    logic       pre;
    logic [0:0] d;
    logic [0:0] q;
    logic [0:0] qbar;

    logic [7:0] ri;
    logic [7:0] ro;
    logic [7:0] rob;
    logic       rres;
    logic       rpre;

    always #5 clk = ~clk;

    d_ff #(.WIDTH(1)) dut (
        .q    (q),
        .qbar (qbar),
        .d    (d),
        .clk  (clk),
        .res  (res),
        .pre  (pre)
    );

    genvar k;
    generate
        for (k = 0; k < 8; k++) begin : g_rot
            d_ff rot (ro[(k+1)%8], rob[(k+1)%8], ri[k], clk, rres, rpre);
        end
    endgenerate

    typedef struct {
        logic res;
        logic pre;
        logic d;
        logic exp_now;
        logic exp_edge;
    } vec_t;

    vec_t       tbl [12];
    logic [0:0] exp_q [$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic push(input logic e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name);
        logic [0:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected value queued", name);
            return;
        end
        e = exp_q.pop_front();
        if (q !== e || qbar !== ~e) begin
            n_bad++;
            $display("FAIL %s: q=%b qbar=%b, required q=%b qbar=%b", name, q, qbar, e, ~e);
        end
    endtask

    initial begin
        //            res   pre   d     now   edge
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        res  = 1'b0;
        pre  = 1'b1;
        d    = 1'b0;
        rres = 1'b0;
        rpre = 1'b1;
        ri   = 8'h00;
        #1;
        push(1'b0);
        check("reset");

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            res = tbl[i].res;
            pre = tbl[i].pre;
            d   = tbl[i].d;
            #1;
            push(tbl[i].exp_now);
            check($sformatf("vec%0d_async", i));
            @(posedge clk);
            #1;
            push(tbl[i].exp_edge);
            check($sformatf("vec%0d_edge", i));
        end

        // Mid-cycle clear with q=1, then clear held across three edges with d=1.
        @(negedge clk);
        res = 1'b1;
        pre = 1'b1;
        d   = 1'b1;
        @(posedge clk);
        #1;
        push(1'b1);
        check("clr_setup");
        #2;
        res = 1'b0;
        #1;
        push(1'b0);
        check("clr_midcycle");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            push(1'b0);
            check($sformatf("clr_hold%0d", i));
        end

        // Clear released in the same timestep as a rising edge: that edge is ignored.
        @(posedge clk);
        res <= 1'b1;
        #1;
        push(1'b0);
        check("coincident_release");
        @(posedge clk);
        #1;
        push(1'b1);
        check("after_release");

        // Rotate register from eight positional instances.
        n_vec++;
        if (ro !== 8'h00 || rob !== 8'hff) begin
            n_bad++;
            $display("FAIL rot_clear: o=%b ob=%b, required o=00000000 ob=11111111", ro, rob);
        end
        @(negedge clk);
        ri   = 8'b1011_0001;
        rres = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (ro !== 8'b0110_0011 || rob !== 8'b1001_1100) begin
            n_bad++;
            $display("FAIL rot_step: o=%b ob=%b, required o=01100011 ob=10011100", ro, rob);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
